// File: rtl/fadd_pkg.sv
// Shared definitions for the pipelined floating-point adder: default widths,
// operand classes, the canonical NaN and the two inter-stage register layouts.
package fadd_pkg;

  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int W    = 1 + EW + MW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int GRS  = 3;
  localparam int MXW  = MW + 1 + GRS;
  localparam int LZW  = $clog2(MW + 6);

  typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, NAN} fclass_t;

  function automatic logic [W-1:0] canon_nan();
    return {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  endfunction

  function automatic fclass_t classify(input logic [EW-1:0] e, input logic [MW-1:0] f);
    if (e == '0) return (f == '0) ? ZERO : SUBN;
    if (e == '1) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  // Mantissas carry hidden bit, fraction and guard/round/sticky.
  typedef struct packed {
    logic           valid;
    logic           spec;
    logic [W-1:0]   spec_val;
    logic           sign;
    logic           eff_sub;
    logic [EW-1:0]  exp;
    logic [MXW-1:0] bm;
    logic [MXW-1:0] sm;
  } s1_t;

  typedef struct packed {
    logic           valid;
    logic           spec;
    logic [W-1:0]   spec_val;
    logic           sign;
    logic           ovfp;
    logic [EW-1:0]  exp;
    logic [MXW-1:0] mant;
    logic [LZW-1:0] lz;
  } s2_t;

endpackage

// File: rtl/fadd_lzc.sv
// Leading-zero counter; an all-zero input reports the full input width.
module fadd_lzc #(
  parameter int WIDTH = 28,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  output logic [OW-1:0]    count
);

  // Scan upward so the most significant set bit decides the count.
  always_comb begin
    count = OW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (a[i]) count = OW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754 adder/subtractor with valid/ready handshake.
// S1 aligns operands and tags specials, S2 adds and counts leading zeros,
// S3 normalises, rounds to nearest-even and resolves specials.
// Stage register layouts come from fadd_pkg, so retarget EW/MW there too.
// Optional macro FADD_PIPE_FTZ_EN: subnormal inputs read as zero and
// results with a zero exponent flush to signed zero.
module fadd_pipe #(
  parameter int EW = fadd_pkg::EW,
  parameter int MW = fadd_pkg::MW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [EW+MW:0] x1,
  input  logic [EW+MW:0] x2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [EW+MW:0] y,
  output logic         ovf
);

  import fadd_pkg::*;

  localparam logic [EW+MW:0] QBIT = {{(EW+1){1'b0}}, 1'b1, {(MW-1){1'b0}}};

  logic           advance;
  s1_t            s1, s1_n;
  s2_t            s2, s2_n;
  logic [EW+MW:0] x2e;
  logic [EW-1:0]  ea, eb, be, se, d;
  logic [MW-1:0]  fa, fb;
  fclass_t        ca, cb;
  logic           a_big;
  logic [MXW-1:0] bmant, smant, mask;
  int             dsat;
  logic [MXW:0]   sum;
  logic [MXW-1:0] m2;
  logic [EW-1:0]  e2;
  logic [LZW-1:0] lz;
  int             sh, lim, e3, ef;
  logic [MXW-1:0] norm;
  logic           rup;
  logic [MW+1:0]  rnd;
  logic [MW-1:0]  ff;
  logic [EW+MW:0] res;
  logic           ovf_c;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // S1: order operands by magnitude, align the smaller one and tag specials.
  always_comb begin
    x2e = {x2[EW+MW] ^ sub, x2[EW+MW-1:0]};
    ea  = x1[EW+MW-1:MW];
    fa  = x1[MW-1:0];
    eb  = x2e[EW+MW-1:MW];
    fb  = x2e[MW-1:0];
`ifdef FADD_PIPE_FTZ_EN
    if (ea == '0) fa = '0;
    if (eb == '0) fb = '0;
`endif
    ca    = classify(ea, fa);
    cb    = classify(eb, fb);
    a_big = {ea, fa} >= {eb, fb};
    be    = a_big ? ea : eb;
    se    = a_big ? eb : ea;
    bmant = {be != '0, a_big ? fa : fb, {GRS{1'b0}}};
    smant = {se != '0, a_big ? fb : fa, {GRS{1'b0}}};
    if (be == '0) be = EW'(1);
    if (se == '0) se = EW'(1);
    d     = be - se;
    dsat  = (int'(d) > MW + 3) ? MW + 3 : int'(d);
    mask  = ~({MXW{1'b1}} << dsat);

    s1_n         = '0;
    s1_n.valid   = in_valid;
    s1_n.sign    = a_big ? x1[EW+MW] : x2e[EW+MW];
    s1_n.eff_sub = x1[EW+MW] ^ x2e[EW+MW];
    s1_n.exp     = be;
    s1_n.bm      = bmant;
    s1_n.sm      = (smant >> dsat) | MXW'(|(smant & mask));
    if (ca == NAN || cb == NAN) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_val = (cb == NAN) ? (x2e | QBIT) : (x1 | QBIT);
    end else if (ca == INF && cb == INF) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_val = (x1[EW+MW] != x2e[EW+MW]) ? canon_nan() : x1;
    end else if (ca == INF) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_val = x1;
    end else if (cb == INF) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_val = x2e;
    end
  end

  // S1 register: all stages move together whenever the output can advance.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)        s1 <= '0;
    else if (advance) s1 <= s1_n;

  // S2 arithmetic: magnitude add or subtract, folding a carry back in.
  always_comb begin
    sum = s1.eff_sub ? ({1'b0, s1.bm} - {1'b0, s1.sm})
                     : ({1'b0, s1.bm} + {1'b0, s1.sm});
    if (sum[MXW]) begin
      m2 = {sum[MXW:2], sum[1] | sum[0]};
      e2 = s1.exp + EW'(1);
    end else begin
      m2 = sum[MXW-1:0];
      e2 = s1.exp;
    end
  end

  fadd_lzc #(.WIDTH(MXW + 1)) u_lzc (
    .a     ({1'b0, m2}),
    .count (lz)
  );

  // S2 next state: an exact cancellation always yields +0.
  always_comb begin
    s2_n          = '0;
    s2_n.valid    = s1.valid;
    s2_n.spec     = s1.spec;
    s2_n.spec_val = s1.spec_val;
    s2_n.sign     = (s1.eff_sub && sum == '0) ? 1'b0 : s1.sign;
    s2_n.ovfp     = sum[MXW] && (e2 == '1);
    s2_n.exp      = e2;
    s2_n.mant     = m2;
    s2_n.lz       = lz;
  end

  // S2 register.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)        s2 <= '0;
    else if (advance) s2 <= s2_n;

  // S3: normalise without going below exponent 1, round, then apply overrides.
  always_comb begin
    lim = int'(s2.exp) - 1;
    sh  = int'(s2.lz) - 1;
`ifndef FADD_PIPE_FTZ_EN
    if (sh > lim) sh = lim;
`endif
    norm = s2.mant << sh;
    e3   = int'(s2.exp) - sh;
    rup  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd  = {1'b0, norm[MXW-1:GRS]} + (MW+2)'(rup);
    if (rnd[MW+1]) begin
      ef = e3 + 1;
      ff = '0;
    end else begin
      ef = rnd[MW] ? e3 : 0;
      ff = rnd[MW-1:0];
    end
    ovf_c = 1'b0;
    res   = {s2.sign, EW'(ef), ff};
`ifdef FADD_PIPE_FTZ_EN
    if (sh > lim || ef == 0) res = {s2.sign, {(EW+MW){1'b0}}};
`endif
    if (s2.ovfp || ef >= (1 << EW) - 1) begin
      res   = {s2.sign, {EW{1'b1}}, {MW{1'b0}}};
      ovf_c = 1'b1;
    end
    if (s2.spec) begin
      res   = s2.spec_val;
      ovf_c = 1'b0;
    end
  end

  // Output register: result is held until the consumer takes it.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2.valid;
      y         <= res;
      ovf       <= s2.valid & ovf_c;
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: single-op latency/results, a back-pressured
// stream and a mid-stream reset. Honours FADD_PIPE_FTZ_EN for expectations.
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [31:0] x1, x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  int testsRun = 0;
  int testsFailed = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  fadd_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Issue one operation into an empty pipe and check it lands after two more edges.
  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expY, input logic expOvf);
    @(negedge clk);
    sub = s; x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_y"}, y, expY);
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
  endtask

  logic [31:0] sA[4], sB[4], sY[4];
  logic        sO[4];
  int          sent, rcvd, seen;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; x1 = '0; x2 = '0;
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_y", y, 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("one_plus_one", 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    applyStimulus("cancel_sub",   1'b1, 32'h40400000, 32'h40400000, 32'h00000000, 1'b0);
    applyStimulus("neg_zeros",    1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    applyStimulus("tie_even",     1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
    applyStimulus("tie_up",       1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
    applyStimulus("overflow",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    applyStimulus("inf_minus_inf",1'b0, 32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0);
    applyStimulus("nan_quiet",    1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FE00000, 1'b0);
    applyStimulus("two_minus_one",1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0);
    applyStimulus("cancel_add",   1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
    applyStimulus("sub_inf",      1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0);
`ifdef FADD_PIPE_FTZ_EN
    applyStimulus("subn_add",     1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0);
    applyStimulus("min_norm_sub", 1'b0, 32'h00800000, 32'h80000001, 32'h00800000, 1'b0);
`else
    applyStimulus("subn_add",     1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0);
    applyStimulus("min_norm_sub", 1'b0, 32'h00800000, 32'h80000001, 32'h007FFFFF, 1'b0);
`endif

    // Drain the last result before streaming.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    sA[0] = 32'h3F800000; sB[0] = 32'h3F800000; sY[0] = 32'h40000000; sO[0] = 1'b0;
    sA[1] = 32'h3F800001; sB[1] = 32'h33800000; sY[1] = 32'h3F800002; sO[1] = 1'b0;
    sA[2] = 32'h7F7FFFFF; sB[2] = 32'h7F7FFFFF; sY[2] = 32'h7F800000; sO[2] = 1'b1;
    sA[3] = 32'h7F800000; sB[3] = 32'hFF800000; sY[3] = 32'hFFC00000; sO[3] = 1'b0;
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc == 3 || cyc == 4);
      sub = 1'b0;
      if (sent < 4) begin
        in_valid = 1'b1; x1 = sA[sent]; x2 = sB[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 3 || cyc == 4) begin
        checkOutput($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
        checkOutput($sformatf("stall_hold_c%0d", cyc), y, sY[0]);
      end
      if (out_valid && out_ready) begin
        if (rcvd < 4) begin
          checkOutput($sformatf("stream_y%0d", rcvd), y, sY[rcvd]);
          checkOutput($sformatf("stream_ovf%0d", rcvd), 32'(ovf), 32'(sO[rcvd]));
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checkOutput("stream_count", 32'(rcvd), 32'd4);

    // Fill the pipe with the consumer stalled, then reset it mid-stream.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; x1 = 32'h3F800000; x2 = 32'h3F800000;
    @(posedge clk);
    #1 x1 = 32'h40400000; x2 = 32'h3F800000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_pre_y", y, 32'h40000000);
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_y", y, 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("rst_no_stale", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
